// File: rtl/vga_sync_rx_if.sv
// Pin-level and recovered-pixel signal bundle for vga_sync_rx.
// Stats outputs exist only when VGA_SYNC_RX_STATS_EN is defined.
interface vga_sync_rx_if #(
  parameter int unsigned R  = 4,
  parameter int unsigned G  = 4,
  parameter int unsigned B  = 4,
  parameter int unsigned CX = 10,
  parameter int unsigned CY = 10
);
  logic [R-1:0]  vga_red;
  logic [G-1:0]  vga_green;
  logic [B-1:0]  vga_blue;
  logic          vga_hsync;
  logic          vga_vsync;
  logic [R-1:0]  pixR;
  logic [G-1:0]  pixG;
  logic [B-1:0]  pixB;
  logic [CX-1:0] pix_x;
  logic [CY-1:0] pix_y;
  logic          pix_valid;
  logic          frame_start;
  logic          locked;
`ifdef VGA_SYNC_RX_STATS_EN
  logic [CX:0]   h_total;
  logic [CY:0]   v_total;
  logic [7:0]    lock_loss_cnt;

  modport master (
    output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync,
    input  pixR, pixG, pixB, pix_x, pix_y, pix_valid, frame_start, locked,
    input  h_total, v_total, lock_loss_cnt
  );
  modport slave (
    input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync,
    output pixR, pixG, pixB, pix_x, pix_y, pix_valid, frame_start, locked,
    output h_total, v_total, lock_loss_cnt
  );
`else
  modport master (
    output vga_red, vga_green, vga_blue, vga_hsync, vga_vsync,
    input  pixR, pixG, pixB, pix_x, pix_y, pix_valid, frame_start, locked
  );
  modport slave (
    input  vga_red, vga_green, vga_blue, vga_hsync, vga_vsync,
    output pixR, pixG, pixB, pix_x, pix_y, pix_valid, frame_start, locked
  );
`endif
endinterface

// File: rtl/vga_sync_rx.sv
// VGA receiver: recovers pixel coordinates from sync pulses, gated by a line-period lock.
// Optional stats outputs (h_total, v_total, lock_loss_cnt) under VGA_SYNC_RX_STATS_EN.
module vga_sync_rx #(
  parameter int unsigned R          = 4,
  parameter int unsigned G          = 4,
  parameter int unsigned B          = 4,
  parameter int unsigned CX         = 10,
  parameter int unsigned CY         = 10,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_START    = 144,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_START    = 35,
  parameter int unsigned LOCK_LINES = 4
) (
  input logic          clk,
  input logic          rst_n,
  vga_sync_rx_if.slave vga
);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  localparam logic [CX:0]   H_LO   = (CX+1)'(H_START);
  localparam logic [CX:0]   H_HI   = (CX+1)'(H_START + H_ACTIVE);
  localparam logic [CY:0]   V_LO   = (CY+1)'(V_START);
  localparam logic [CY:0]   V_HI   = (CY+1)'(V_START + V_ACTIVE);
  localparam int unsigned   MW     = $clog2(LOCK_LINES + 1);
  localparam logic [MW-1:0] LOCK_M = MW'(LOCK_LINES);

  logic [R-1:0]  red1_q;
  logic [G-1:0]  green1_q;
  logic [B-1:0]  blue1_q;
  logic          hs1_q, vs1_q, hs2_q, vs2_q;
  logic [CX:0]   h_cnt_q, h_cnt_d;
  logic [CY:0]   v_line_q, v_line_d;
  logic [CX:0]   last_period_q, last_period_d, period;
  logic [MW-1:0] match_cnt_q, match_cnt_d;
  state_t        state_q, state_d;

  logic [R-1:0]  pixR_q, pixR_d;
  logic [G-1:0]  pixG_q, pixG_d;
  logic [B-1:0]  pixB_q, pixB_d;
  logic [CX-1:0] pix_x_q, pix_x_d;
  logic [CY-1:0] pix_y_q, pix_y_d;
  logic          pix_valid_q, frame_start_q, frame_start_d;

  logic hfall, vfall, period_match, h_sat, in_win;

  always_comb begin
    hfall         = ~hs1_q & hs2_q;
    vfall         = ~vs1_q & vs2_q;
    period        = h_cnt_q + 1'b1;
    period_match  = (period == last_period_q);
    h_sat         = &h_cnt_q;

    h_cnt_d       = hfall ? '0 : (h_sat ? h_cnt_q : h_cnt_q + 1'b1);
    last_period_d = hfall ? period : last_period_q;

    v_line_d = v_line_q;
    if (vfall)                   v_line_d = '0;
    else if (hfall && !(&v_line_q)) v_line_d = v_line_q + 1'b1;

    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    case (state_q)
      SEARCH: if (hfall) begin
        state_d     = TRACK;
        match_cnt_d = '0;
      end
      TRACK: begin
        // A mismatch in the same cycle as vsync fall must block the lock.
        if (hfall && !period_match) begin
          match_cnt_d = '0;
        end else begin
          if (vfall && match_cnt_q >= LOCK_M) state_d = LOCKED;
          if (hfall && match_cnt_q < LOCK_M)  match_cnt_d = match_cnt_q + 1'b1;
        end
      end
      LOCKED: if ((hfall && !period_match) || h_sat) state_d = SEARCH;
      default: state_d = SEARCH;
    endcase

    // Window is judged on next-state counters so outputs line up with the colour two cycles after the pins.
    in_win = (state_d == LOCKED) && (h_cnt_d >= H_LO) && (h_cnt_d < H_HI)
             && (v_line_d >= V_LO) && (v_line_d < V_HI);

    pixR_d        = in_win ? red1_q   : '0;
    pixG_d        = in_win ? green1_q : '0;
    pixB_d        = in_win ? blue1_q  : '0;
    pix_x_d       = in_win ? CX'(h_cnt_d - H_LO)  : '0;
    pix_y_d       = in_win ? CY'(v_line_d - V_LO) : '0;
    frame_start_d = in_win && (h_cnt_d == H_LO) && (v_line_d == V_LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red1_q        <= '0;
      green1_q      <= '0;
      blue1_q       <= '0;
      hs1_q         <= 1'b1;
      vs1_q         <= 1'b1;
      hs2_q         <= 1'b1;
      vs2_q         <= 1'b1;
      h_cnt_q       <= '0;
      v_line_q      <= '0;
      last_period_q <= '0;
      match_cnt_q   <= '0;
      state_q       <= SEARCH;
      pixR_q        <= '0;
      pixG_q        <= '0;
      pixB_q        <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      red1_q        <= vga.vga_red;
      green1_q      <= vga.vga_green;
      blue1_q       <= vga.vga_blue;
      hs1_q         <= vga.vga_hsync;
      vs1_q         <= vga.vga_vsync;
      hs2_q         <= hs1_q;
      vs2_q         <= vs1_q;
      h_cnt_q       <= h_cnt_d;
      v_line_q      <= v_line_d;
      last_period_q <= last_period_d;
      match_cnt_q   <= match_cnt_d;
      state_q       <= state_d;
      pixR_q        <= pixR_d;
      pixG_q        <= pixG_d;
      pixB_q        <= pixB_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_valid_q   <= in_win;
      frame_start_q <= frame_start_d;
    end
  end

  assign vga.pixR        = pixR_q;
  assign vga.pixG        = pixG_q;
  assign vga.pixB        = pixB_q;
  assign vga.pix_x       = pix_x_q;
  assign vga.pix_y       = pix_y_q;
  assign vga.pix_valid   = pix_valid_q;
  assign vga.frame_start = frame_start_q;
  assign vga.locked      = (state_q == LOCKED);

`ifdef VGA_SYNC_RX_STATS_EN
  logic [CY:0] v_total_q;
  logic [7:0]  lock_loss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_total_q   <= '0;
      lock_loss_q <= '0;
    end else begin
      // The hsync fall coinciding with vsync fall closes the frame, hence the +1.
      if (vfall) v_total_q <= (&v_line_q) ? v_line_q : v_line_q + 1'b1;
      if (state_q == LOCKED && state_d == SEARCH && lock_loss_q != '1)
        lock_loss_q <= lock_loss_q + 1'b1;
    end
  end

  assign vga.h_total       = last_period_q;
  assign vga.v_total       = v_total_q;
  assign vga.lock_loss_cnt = lock_loss_q;
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// Scoreboard bench for vga_sync_rx on a scaled-down 40x12 raster (24x6 visible).
module tb_vga_sync_rx;
  localparam int CX = 10, CY = 10;
  localparam int H_START = 10, H_ACTIVE = 24, V_START = 4, V_ACTIVE = 6;
  localparam int HT = 40, VT = 12, HS_W = 6, VS_L = 2;

  typedef struct packed {
    logic [CX-1:0] x;
    logic [CY-1:0] y;
    logic [3:0]    r;
    logic [3:0]    g;
    logic [3:0]    b;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_sync_rx_if #(.R(4), .G(4), .B(4), .CX(CX), .CY(CY)) bus ();

  vga_sync_rx #(
    .R(4), .G(4), .B(4), .CX(CX), .CY(CY),
    .H_ACTIVE(H_ACTIVE), .H_START(H_START),
    .V_ACTIVE(V_ACTIVE), .V_START(V_START), .LOCK_LINES(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vga  (bus)
  );

  pix_t exp_q[$];
  int n_tests = 0, n_fail = 0;
  int valid_seen = 0, valid_exp = 0, fs_seen = 0, fs_exp = 0;
  int vbase, fbase;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, got, req, $time);
    end
  endfunction

  pix_t mon_got, mon_exp;
  always @(negedge clk) begin
    mon_got = '{x: bus.pix_x, y: bus.pix_y, r: bus.pixR, g: bus.pixG, b: bus.pixB};
    if (bus.pix_valid === 1'b1) begin
      valid_seen++;
      if (bus.frame_start === 1'b1) fs_seen++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_valid: got pix_valid=1 x=%0d y=%0d, required pix_valid=0 (t=%0t)",
                 bus.pix_x, bus.pix_y, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pixel", mon_got, mon_exp);
        check("frame_start", bus.frame_start, (mon_exp.x == 0 && mon_exp.y == 0));
      end
    end else begin
      check("idle_zero", {mon_got, bus.frame_start}, '0);
    end
  end

  task automatic drive(input int l, input int c, input bit push);
    int x, y;
    bit vis;
    pix_t e;
    x = c - H_START;
    y = l - V_START;
    vis = (x >= 0) && (x < H_ACTIVE) && (y >= 0) && (y < V_ACTIVE);
    @(posedge clk);
    #1;
    bus.vga_hsync = (c < HS_W) ? 1'b0 : 1'b1;
    bus.vga_vsync = (l < VS_L) ? 1'b0 : 1'b1;
    if (vis) begin
      e.x = x[CX-1:0];
      e.y = y[CY-1:0];
      e.r = x[3:0];
      e.g = y[3:0];
      e.b = x[3:0] ^ y[3:0];
      bus.vga_red = e.r; bus.vga_green = e.g; bus.vga_blue = e.b;
      if (push) begin
        exp_q.push_back(e);
        valid_exp++;
        if (x == 0 && y == 0) fs_exp++;
      end
    end else begin
      bus.vga_red = 4'($urandom); bus.vga_green = 4'($urandom); bus.vga_blue = 4'($urandom);
    end
  endtask

  task automatic drive_line(input int l, input int c0, input int c1, input bit push);
    for (int c = c0; c < c1; c++) drive(l, c, push);
  endtask

  task automatic drive_frame(input bit push);
    for (int l = 0; l < VT; l++) drive_line(l, 0, HT, push);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(VS_L, HT - 1, 1'b0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {bus.pixR, bus.pixG, bus.pixB, bus.pix_x, bus.pix_y,
                 bus.pix_valid, bus.frame_start, bus.locked}, '0);
  endtask

  initial begin
    bus.vga_hsync = 1'b1; bus.vga_vsync = 1'b1;
    bus.vga_red = '0; bus.vga_green = '0; bus.vga_blue = '0;
    repeat (3) @(posedge clk);
    #2 check_all_zero("reset_outputs");
    @(negedge clk) rst_n = 1'b1;
    idle(10);

    // F1 acquires, F2 is the first locked frame
    drive_frame(1'b0);
    check("unlocked_after_f1", bus.locked, 1'b0);
    vbase = valid_seen; fbase = fs_seen;
    drive_line(0, 0, 3, 1'b1);
    check("lock_at_vsync", bus.locked, 1'b1);
    drive_line(0, 3, HT, 1'b1);
    for (int l = 1; l < VT; l++) drive_line(l, 0, HT, 1'b1);
    check("valid_per_frame", valid_seen - vbase, H_ACTIVE * V_ACTIVE);
    check("fs_per_frame", fs_seen - fbase, 1);
`ifdef VGA_SYNC_RX_STATS_EN
    check("h_total", bus.h_total, HT);
    check("v_total", bus.v_total, VT);
`endif

    // F3: line 6 is one cycle short
    for (int l = 0; l < 6; l++) drive_line(l, 0, HT, 1'b1);
    drive_line(6, 0, HT - 1, 1'b1);
    check("locked_before_short", bus.locked, 1'b1);
    drive_line(7, 0, 3, 1'b0);
    check("unlock_after_short", bus.locked, 1'b0);
    check("valid_after_short", bus.pix_valid, 1'b0);
    drive_line(7, 3, HT, 1'b0);
    for (int l = 8; l < VT; l++) drive_line(l, 0, HT, 1'b0);
    drive_frame(1'b0);
    check("no_lock_before_vsync", bus.locked, 1'b0);
    drive_line(0, 0, 3, 1'b1);
    check("relock_at_vsync", bus.locked, 1'b1);
    drive_line(0, 3, HT, 1'b1);
    for (int l = 1; l < VT; l++) drive_line(l, 0, HT, 1'b1);
`ifdef VGA_SYNC_RX_STATS_EN
    check("lock_loss_cnt", bus.lock_loss_cnt, 1);
`endif

    // hsync stuck high until h_cnt saturates
    idle(1500);
    check("locked_before_sat", bus.locked, 1'b1);
    idle(700);
    check_all_zero("sat_outputs");

    // reacquire, then reset mid-line in a locked frame
    drive_frame(1'b0);
    for (int l = 0; l < 5; l++) drive_line(l, 0, HT, 1'b1);
    drive_line(5, 0, 20, 1'b1);
    @(posedge clk);
    #3 check("valid_before_reset", bus.pix_valid, 1'b1);
    rst_n = 1'b0;
    #1 check_all_zero("async_reset_outputs");
    valid_exp -= exp_q.size();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_line(5, 20, HT, 1'b0);
    for (int l = 6; l < VT; l++) drive_line(l, 0, HT, 1'b0);
    check("unlocked_after_reset", bus.locked, 1'b0);
    drive_frame(1'b1);
    idle(4);

    check("queue_drained", exp_q.size(), 0);
    check("valid_total", valid_seen, valid_exp);
    check("fs_total", fs_seen, fs_exp);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
